// File: rtl/dm_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the alignment rule used when a request is accepted.
package dm_responder_pkg;

  localparam logic [1:0] DM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] DM_SIZE_HALF = 2'b01;
  localparam logic [1:0] DM_SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACC  = 3'd2,
    ST_RESP = 3'd3,
    ST_ERR  = 3'd4
  } dm_state_e;

  // Size 11 has no lane mapping, so it is rejected like a misaligned access.
  function automatic logic dm_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      DM_SIZE_BYTE: bad = 1'b0;
      DM_SIZE_HALF: bad = addr_lo[0];
      DM_SIZE_WORD: bad = (addr_lo != 2'b00);
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering: store byte enables and data replication, plus
// load extraction with sign/zero extension. Purely combinational.
module dm_lane
  import dm_responder_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // select the addressed byte and halfword out of the read word
  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      2'd3:    w_byte = i_rword[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_rword[31:16];
    end else begin
      w_half = i_rword[15:0];
    end
  end

  // Store data is replicated across lanes; the enables pick the lanes that land.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0000_0000;
    o_rdata = 32'h0000_0000;
    case (i_size)
      DM_SIZE_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        if (i_uns) begin
          o_rdata = {24'h00_0000, w_byte};
        end else begin
          o_rdata = {{24{w_byte[7]}}, w_byte};
        end
      end
      DM_SIZE_HALF: begin
        if (i_addr_lo[1]) begin
          o_be = 4'b1100;
        end else begin
          o_be = 4'b0011;
        end
        o_wdata = {2{i_wdata[15:0]}};
        if (i_uns) begin
          o_rdata = {16'h0000, w_half};
        end else begin
          o_rdata = {{16{w_half[15]}}, w_half};
        end
      end
      DM_SIZE_WORD: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = 32'h0000_0000;
        o_rdata = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, LATENCY wait states, then a
// one-cycle ready pulse (with err for misaligned/illegal-size requests).
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_err
);

  localparam logic [2:0] CNT_INIT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  dm_state_e         r_state;
  dm_state_e         w_next;
  logic [2:0]        r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_ready;
  logic              r_busy;
  logic              r_err;
  logic [31:0]       r_mem [2**ADDR_W];

  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_rword;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_al;
  logic [31:0]       w_load;

  assign w_idx   = r_addr[ADDR_W+1:2];
  assign w_rword = r_mem[w_idx];

  dm_lane u_lane (
    .i_size    (r_size),
    .i_uns     (r_uns),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wdata   (w_wdata_al),
    .o_rdata   (w_load)
  );

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!i_req) begin
          w_next = ST_IDLE;
        end else if (dm_misaligned(i_size, i_addr[1:0])) begin
          w_next = ST_ERR;
        end else if (LATENCY == 0) begin
          w_next = ST_ACC;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_next = ST_ACC;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_ACC:  w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // state, wait counter and request latches; inputs are only looked at in IDLE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_we    <= 1'b0;
      r_size  <= DM_SIZE_BYTE;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0000_0000;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && i_req) begin
        r_cnt   <= CNT_INIT;
        r_we    <= i_we;
        r_size  <= i_size;
        r_uns   <= i_uns;
        r_addr  <= i_addr[ADDR_W+1:0];
        r_wdata <= i_wdata;
      end else if (r_state == ST_WAIT && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // registered outputs, derived from the state being entered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= 32'h0000_0000;
    end else begin
      r_ready <= (w_next == ST_RESP) || (w_next == ST_ERR);
      r_err   <= (w_next == ST_ERR);
      r_busy  <= (w_next != ST_IDLE);
      if (r_state == ST_ACC) begin
        r_rdata <= r_we ? 32'h0000_0000 : w_load;
      end else if (w_next == ST_ERR) begin
        r_rdata <= 32'h0000_0000;
      end
    end
  end

  // Memory is not reset; a reset before the ACC edge leaves it untouched.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_ACC && r_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_al[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_rdata;
  assign o_ready = r_ready;
  assign o_busy  = r_busy;
  assign o_err   = r_err;

endmodule

// File: tb/tb_dm_responder.sv
// Randomized self-checking bench: a LATENCY=2 and a LATENCY=0 responder
// checked against a byte-array memory model.
module tb_dm_responder;
  import dm_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_s, req_f, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_s, rdata_f;
  logic        rdy_s, rdy_f, busy_s, busy_f, err_s, err_f;
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  mem_m [2][64];

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(10), .LATENCY(2)) u_slow (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_s), .i_we(we), .i_size(size), .i_uns(uns),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata_s), .o_ready(rdy_s), .o_busy(busy_s), .o_err(err_s)
  );

  dm_responder #(.ADDR_W(10), .LATENCY(0)) u_fast (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_f), .i_we(we), .i_size(size), .i_uns(uns),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata_f), .o_ready(rdy_f), .o_busy(busy_f), .o_err(err_f)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic get_rdy(input int d);
    return (d == 0) ? rdy_s : rdy_f;
  endfunction
  function automatic logic get_busy(input int d);
    return (d == 0) ? busy_s : busy_f;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? err_s : err_f;
  endfunction
  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? rdata_s : rdata_f;
  endfunction

  function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] a);
    int nbytes;
    if (sz == 2'd3) return 1'b1;
    nbytes = 1 << sz;
    return (a % nbytes) != 0;
  endfunction

  // little-endian read of 1/2/4 bytes, then extension
  function automatic logic [31:0] model_load(input int d, input logic [1:0] sz, input logic u, input logic [31:0] a);
    int o = int'(a[5:0]);
    int nbytes = 1 << sz;
    logic [31:0] v = 32'd0;
    for (int k = nbytes - 1; k >= 0; k--) v = (v << 8) | 32'(mem_m[d][o + k]);
    if (nbytes == 4 || u) return v;
    if (nbytes == 1) return (v >= 32'd128) ? v - 32'd256 : v;
    return (v >= 32'd32768) ? v - 32'd65536 : v;
  endfunction

  task automatic model_store(input int d, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int o = int'(a[5:0]);
    int nbytes = 1 << sz;
    for (int k = 0; k < nbytes; k++) mem_m[d][o + k] = 8'((wd >> (8 * k)) & 32'hFF);
  endtask

  task automatic access(input int d, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    bit e;
    bit got;
    int n;
    logic [31:0] exp_rd;
    int lat_exp;
    e       = is_bad(sz, a);
    exp_rd  = (e || w) ? 32'd0 : model_load(d, sz, u, a);
    lat_exp = e ? 0 : ((d == 0) ? 3 : 1);
    @(posedge clk); #1;
    we = w; size = sz; uns = u; addr = a; wdata = wd;
    if (d == 0) req_s = 1'b1; else req_f = 1'b1;
    @(posedge clk);
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) chk({tag, " busy"}, 32'(get_busy(d)), 32'd1);
      if (get_rdy(d)) begin
        got = 1'b1;
        n = i;
        break;
      end
    end
    req_s = 1'b0;
    req_f = 1'b0;
    chk({tag, " ready_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, " latency"}, 32'(n), 32'(lat_exp));
      chk({tag, " err"}, 32'(get_err(d)), 32'(e));
      if (!w || e) chk({tag, " rdata"}, get_rdata(d), exp_rd);
      @(negedge clk);
      chk({tag, " ready_pulse"}, 32'(get_rdy(d)), 32'd0);
    end
    if (w && !e) model_store(d, sz, a, wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, nrdy;
    rst_n = 1'b0; req_s = 1'b0; req_f = 1'b0; we = 1'b0; uns = 1'b0;
    size = 2'b00; addr = 32'd0; wdata = 32'd0;
    #12;
    chk("rst ready", {30'd0, rdy_s, rdy_f}, 32'd0);
    chk("rst busy", {30'd0, busy_s, busy_f}, 32'd0);
    chk("rst err", {30'd0, err_s, err_f}, 32'd0);
    chk("rst rdata_s", rdata_s, 32'd0);
    chk("rst rdata_f", rdata_f, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int wi = 0; wi < 16; wi++) access(d, 1'b1, DM_SIZE_WORD, 1'b0, 32'(wi * 4), $urandom(), "init");

    for (int d = 0; d < 2; d++) begin
      access(d, 1'b1, DM_SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF, "t1 sw");
      access(d, 1'b0, DM_SIZE_WORD, 1'b0, 32'h10, 32'd0, "t1 lw");
      access(d, 1'b1, DM_SIZE_BYTE, 1'b0, 32'h13, 32'h80, "t2 sb");
      access(d, 1'b0, DM_SIZE_BYTE, 1'b0, 32'h13, 32'd0, "t2 lb");
      access(d, 1'b0, DM_SIZE_BYTE, 1'b1, 32'h13, 32'd0, "t2 lbu");
      access(d, 1'b0, DM_SIZE_WORD, 1'b0, 32'h10, 32'd0, "t2 lw");
      access(d, 1'b1, DM_SIZE_HALF, 1'b0, 32'h12, 32'h8001, "t3 sh");
      access(d, 1'b0, DM_SIZE_HALF, 1'b0, 32'h12, 32'd0, "t3 lh");
      access(d, 1'b0, DM_SIZE_HALF, 1'b1, 32'h12, 32'd0, "t3 lhu");
      access(d, 1'b0, DM_SIZE_WORD, 1'b0, 32'h10, 32'd0, "t3 lw");
      access(d, 1'b0, DM_SIZE_WORD, 1'b0, 32'h11, 32'd0, "t4 lw mis");
      access(d, 1'b1, DM_SIZE_HALF, 1'b0, 32'h13, 32'hFFFF, "t4 sh mis");
      access(d, 1'b0, DM_SIZE_WORD, 1'b0, 32'h10, 32'd0, "t4 lw");
    end
    chk("t1 model word", model_load(0, DM_SIZE_WORD, 1'b0, 32'h10), 32'h8001BEEF);

    // held request plus a pulse during WAIT: one response, next accepted after RESP
    @(posedge clk); #1;
    we = 1'b1; size = DM_SIZE_WORD; addr = 32'h24; wdata = 32'hA5A5_0001; req_s = 1'b1;
    @(posedge clk);
    first = -1; second = -1; nrdy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin req_s = 1'b0; addr = 32'h28; wdata = 32'h5A5A_0002; end
      if (i == 1) req_s = 1'b1;
      if (rdy_s) begin
        nrdy++;
        if (first < 0) first = i; else if (second < 0) begin second = i; req_s = 1'b0; end
      end
    end
    chk("t5 first ready", 32'(first), 32'd3);
    chk("t5 second ready", 32'(second), 32'd8);
    chk("t5 ready count", 32'(nrdy), 32'd2);
    model_store(0, DM_SIZE_WORD, 32'h24, 32'hA5A5_0001);
    model_store(0, DM_SIZE_WORD, 32'h28, 32'h5A5A_0002);
    access(0, 1'b0, DM_SIZE_WORD, 1'b0, 32'h24, 32'd0, "t5 lw first");
    access(0, 1'b0, DM_SIZE_WORD, 1'b0, 32'h28, 32'd0, "t5 lw second");

    // reset while waiting: nothing is written
    @(posedge clk); #1;
    we = 1'b1; size = DM_SIZE_WORD; addr = 32'h20; wdata = 32'h1234; req_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6 busy before rst", 32'(busy_s), 32'd1);
    rst_n = 1'b0; req_s = 1'b0;
    #1;
    chk("t6 rst outs", {29'd0, rdy_s, busy_s, err_s}, 32'd0);
    chk("t6 rst rdata", rdata_s, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 1'b0, DM_SIZE_WORD, 1'b0, 32'h20, 32'd0, "t6 lw old");

    for (int r = 0; r < 80; r++) begin
      int d;
      logic w, u;
      logic [1:0] sz;
      logic [31:0] a;
      d  = int'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 60));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      access(d, w, sz, u, a, $urandom(), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
